instruction_decode_queue: RTL and testbench
===========================================

Name: instruction_decode_queue

Overview:
- Fetch-to-decode buffer that sits directly upstream of the immediate generation unit.
- Accepts raw 32-bit instructions with their PC from fetch over a valid/ready handshake and stores them in a small FIFO.
- Classifies each instruction's format (R/I/S/B/U/J) on enqueue. The 3-bit format code and instruction are presented to decode and immediate generation from the FIFO head.
- Provides a flush for branch and jump redirects.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2
- PC_WIDTH, 32, width of the stored program counter

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all entries (redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept; equals !full
- in_instruction  input  32  raw instruction word
- in_pc  input  PC_WIDTH  address of in_instruction
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes head
- out_instruction  output  32  head instruction; bits [31:7] feed immediate generator
- out_pc  output  PC_WIDTH  head PC
- out_instruction_type  output  3  head format code (R/I/S/B/U/J constants)
- out_illegal  output  1  head opcode not recognised
- occupancy  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, active-high):
  - Read pointer, write pointer and occupancy go to 0.
  - out_valid=0, in_ready=1.
  - All storage entries are cleared to 0, so out_* read 0 and never X.
- Push: occurs when in_valid && in_ready && !flush. The entry is written at the write pointer, and the write pointer increments modulo DEPTH (natural wrap).
- Pop: occurs when out_valid && out_ready && !flush. The read pointer increments modulo DEPTH.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This is legal only while not full, because in_ready=!full. There is no full-bypass, so no combinational path runs from out_ready to in_ready.
- No empty-bypass: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1 at the earliest. Minimum latency is 1 cycle.
- out_* are driven combinationally from the entry at the read pointer. When out_valid=0 they are don't-care but deterministic.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Pointers and occupancy return to 0, out_valid=0 from the next cycle.
  - An instruction offered during the flush cycle is dropped, even if in_ready=1.
  - Storage contents need not be cleared.
- Classification is computed on in_instruction at enqueue and stored with the entry, using opcode bits [6:0]:
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - any other opcode (including bits[1:0]!=11, i.e. compressed) -> type R, illegal=1
- Full: occupancy==DEPTH, in_ready=0, and in_valid is ignored.
- Empty: occupancy==0, out_valid=0, and out_ready is ignored. occupancy never underflows or overflows.
- Stability: while out_valid=1 and out_ready=0, all out_* are held stable.

Decomposition:
- Format encodings R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE (3-bit) come from the shared defines file.
- Opcode constants (OP, OP_IMM, LOAD, JALR, SYSTEM, FENCE, STORE, BRANCH, LUI, AUIPC, JAL) are added to the same shared defines file.
- One combinational sub-module, instruction_type_classifier, maps opcode[6:0] to {instruction_type, illegal}. It is instantiated once on the enqueue path.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, occupancy=0, out_instruction=0.
- Push 0x00500093 (addi) at cycle N with out_ready=0 -> out_valid=1 at N+1, out_instruction_type=I_TYPE, out_illegal=0, out_pc=in_pc; outputs held until out_ready=1.
- Push 4 instructions with out_ready=0 -> occupancy=4, in_ready=0; 5th offer ignored; drain returns instructions in order: sw 0x00112023 S, beq 0x00000463 B, lui 0x123450B7 U, jal 0x008000EF J.
- Continuous push/pop over 10 entries with DEPTH=4 -> pointer wrap is transparent, order preserved, occupancy steady at 1.
- Queue holds 3 entries, flush=1 with in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, offered instruction not stored.
- Push 0x00000001 (compressed) and 0xFFFFFFFF -> out_illegal=1, out_instruction_type=R_TYPE.
- Assert reset asynchronously mid-drain -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_decode_queue_pkg.sv
// Shared defines for the fetch-to-decode queue: format codes, opcodes, helpers.
package instruction_decode_queue_pkg;

   // 3-bit instruction format codes presented to decode / immediate generation
   typedef enum logic [2:0] {
      R_TYPE = 3'd0,
      I_TYPE = 3'd1,
      S_TYPE = 3'd2,
      B_TYPE = 3'd3,
      U_TYPE = 3'd4,
      J_TYPE = 3'd5
   } instr_type_e;

   // Base-ISA major opcodes, bits [6:0]
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[6:0];
   endfunction

endpackage

// File: rtl/instruction_decode_queue_classifier.sv
// Maps a major opcode to its instruction format; unknown opcodes are flagged illegal.
module instruction_type_classifier
   import instruction_decode_queue_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] instruction_type,
   output logic       illegal
);

   // Opcode decode; anything not listed (compressed included) reports R with illegal set
   always_comb begin
      instruction_type = R_TYPE;
      illegal          = 1'b0;
      case (opcode)
         OP:                                   instruction_type = R_TYPE;
         OP_IMM, LOAD, JALR, SYSTEM, FENCE:    instruction_type = I_TYPE;
         STORE:                                instruction_type = S_TYPE;
         BRANCH:                               instruction_type = B_TYPE;
         LUI, AUIPC:                           instruction_type = U_TYPE;
         JAL:                                  instruction_type = J_TYPE;
         default: begin
            instruction_type = R_TYPE;
            illegal          = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instruction_decode_queue.sv
// Fetch-to-decode FIFO. Instructions are classified once on enqueue and the
// format travels with the entry, so the head outputs are a plain array read.
module instruction_decode_queue
   import instruction_decode_queue_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instruction,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instruction,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [2:0]                 out_instruction_type,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [31:0]         mem_instr   [DEPTH];
   logic [PC_WIDTH-1:0] mem_pc      [DEPTH];
   logic [2:0]          mem_type    [DEPTH];
   logic                mem_illegal [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [2:0]       in_type;
   logic             in_illegal;

   instruction_type_classifier u_classifier (
      .opcode           (opcode_of(in_instruction)),
      .instruction_type (in_type),
      .illegal          (in_illegal)
   );

   // Handshake qualifiers; full/empty come only from registered occupancy,
   // so in_ready never depends on out_ready.
   assign full      = (occupancy == OCC_W'(DEPTH));
   assign empty     = (occupancy == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Pointer and occupancy tracking; flush wins over push and pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head outputs are never X
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr[i]   <= '0;
            mem_pc[i]      <= '0;
            mem_type[i]    <= '0;
            mem_illegal[i] <= 1'b0;
         end
      end else if (push) begin
         mem_instr[wr_ptr]   <= in_instruction;
         mem_pc[wr_ptr]      <= in_pc;
         mem_type[wr_ptr]    <= in_type;
         mem_illegal[wr_ptr] <= in_illegal;
      end
   end

   assign out_instruction      = mem_instr[rd_ptr];
   assign out_pc               = mem_pc[rd_ptr];
   assign out_instruction_type = mem_type[rd_ptr];
   assign out_illegal          = mem_illegal[rd_ptr];

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Self-checking bench for the fetch-to-decode queue.
module tb_instruction_decode_queue;
   import instruction_decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PCW   = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_instruction = '0;
   logic [PCW-1:0]  in_pc = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [31:0]     out_instruction;
   logic [PCW-1:0]  out_pc;
   logic [2:0]      out_instruction_type;
   logic            out_illegal;
   logic [2:0]      occupancy;

   int passed = 0;
   int total  = 0;

   instruction_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .flush                (flush),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_instruction       (in_instruction),
      .in_pc                (in_pc),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .out_instruction      (out_instruction),
      .out_pc               (out_pc),
      .out_instruction_type (out_instruction_type),
      .out_illegal          (out_illegal),
      .occupancy            (occupancy)
   );

   always #5 clk = ~clk;

   // Reference classification straight from the opcode table: {type, illegal}
   function automatic logic [3:0] ref_class(input logic [31:0] instr);
      logic [6:0] op;
      op = instr[6:0];
      case (op)
         7'b0110011:                                       return {3'd0, 1'b0};
         7'b0010011, 7'b0000011, 7'b1100111,
         7'b1110011, 7'b0001111:                           return {3'd1, 1'b0};
         7'b0100011:                                       return {3'd2, 1'b0};
         7'b1100011:                                       return {3'd3, 1'b0};
         7'b0110111, 7'b0010111:                           return {3'd4, 1'b0};
         7'b1101111:                                       return {3'd5, 1'b0};
         default:                                          return {3'd0, 1'b1};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instruction = '0; in_pc = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      #12;
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
      total++; if (occupancy !== 3'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else passed++;
      total++; if (out_instruction !== 32'h0) $display("FAIL reset_out_instruction got %h exp 0", out_instruction); else passed++;
   endtask

   task automatic test_single_push();
      in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h0000_0100; out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL no_bypass got %b exp 0", out_valid); else passed++;
      step();
      in_valid = 1'b0; in_instruction = 32'hDEAD_BEEF; in_pc = 32'hFFFF_FFFF;
      total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else passed++;
      total++; if (out_instruction_type !== I_TYPE) $display("FAIL single_type got %0d exp %0d", out_instruction_type, I_TYPE); else passed++;
      total++; if (out_illegal !== 1'b0) $display("FAIL single_illegal got %b exp 0", out_illegal); else passed++;
      total++; if (out_pc !== 32'h0000_0100) $display("FAIL single_pc got %h exp 100", out_pc); else passed++;
      repeat (3) begin
         step();
         total++;
         if (out_valid !== 1'b1 || out_instruction !== 32'h00500093 || out_pc !== 32'h100)
            $display("FAIL single_hold got v=%b i=%h pc=%h exp v=1 i=00500093 pc=100", out_valid, out_instruction, out_pc);
         else passed++;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL single_pop got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_fill_drain();
      logic [31:0] seq [4];
      logic [2:0]  typ [4];
      seq[0] = 32'h00112023; typ[0] = S_TYPE;
      seq[1] = 32'h00000463; typ[1] = B_TYPE;
      seq[2] = 32'h123450B7; typ[2] = U_TYPE;
      seq[3] = 32'h008000EF; typ[3] = J_TYPE;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_instruction = seq[i]; in_pc = 32'h200 + 32'(i * 4);
         step();
      end
      total++; if (occupancy !== 3'd4) $display("FAIL fill_occupancy got %0d exp 4", occupancy); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else passed++;
      in_instruction = 32'h00000033; in_pc = 32'h999;
      step();
      in_valid = 1'b0;
      total++; if (occupancy !== 3'd4) $display("FAIL fill_fifth_ignored got %0d exp 4", occupancy); else passed++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_instruction !== seq[i] || out_instruction_type !== typ[i] ||
             out_pc !== 32'h200 + 32'(i * 4))
            $display("FAIL drain_%0d got v=%b i=%h t=%0d pc=%h exp i=%h t=%0d", i, out_valid,
                     out_instruction, out_instruction_type, out_pc, seq[i], typ[i]);
         else passed++;
         step();
      end
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL drain_empty got v=%b occ=%0d exp 0 0", out_valid, occupancy); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = 32'h0040_0013;
      in_valid = 1'b1; out_ready = 1'b1;
      in_instruction = base; in_pc = 32'h1000;
      step();
      for (int k = 1; k <= 10; k++) begin
         total++;
         if (occupancy !== 3'd1 || out_instruction !== base + 32'((k - 1) << 20) ||
             out_pc !== 32'h1000 + 32'((k - 1) * 4))
            $display("FAIL b2b_%0d got occ=%0d i=%h pc=%h exp occ=1 i=%h", k, occupancy,
                     out_instruction, out_pc, base + 32'((k - 1) << 20));
         else passed++;
         if (k < 10) begin
            in_instruction = base + 32'(k << 20); in_pc = 32'h1000 + 32'(k * 4);
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      out_ready = 1'b0;
      total++; if (occupancy !== 3'd0) $display("FAIL b2b_final got %0d exp 0", occupancy); else passed++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instruction = 32'h00000033 + 32'(i << 7); in_pc = 32'(i);
         step();
      end
      in_instruction = 32'h0000006F; in_pc = 32'h777; flush = 1'b1;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_pre_ready got %b exp 1", in_ready); else passed++;
      step();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_clear got occ=%0d v=%b exp 0 0", occupancy, out_valid); else passed++;
      step();
      total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_dropped got occ=%0d v=%b exp 0 0", occupancy, out_valid); else passed++;
   endtask

   task automatic test_illegal();
      logic [31:0] bad [2];
      bad[0] = 32'h00000001; bad[1] = 32'hFFFFFFFF;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_instruction = bad[i]; in_pc = 32'h40 + 32'(i);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (out_instruction !== bad[i] || out_illegal !== 1'b1 || out_instruction_type !== R_TYPE)
            $display("FAIL illegal_%0d got i=%h ill=%b t=%0d exp i=%h ill=1 t=0", i, out_instruction,
                     out_illegal, out_instruction_type, bad[i]);
         else passed++;
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] mq_instr [$];
      logic [31:0] mq_pc [$];
      logic [6:0]  ops [13];
      logic [31:0] r;
      logic [3:0]  cls;
      int          sz;
      bit          do_pop, do_push;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000001, 7'b1011011};
      for (int c = 0; c < 600; c++) begin
         sz = mq_instr.size();
         total++;
         if (out_valid !== (sz > 0) || occupancy !== 3'(sz) || in_ready !== (sz < DEPTH))
            $display("FAIL rand_status cyc %0d got v=%b occ=%0d rdy=%b exp size %0d", c, out_valid, occupancy, in_ready, sz);
         else passed++;
         if (sz > 0) begin
            cls = ref_class(mq_instr[0]);
            total++;
            if (out_instruction !== mq_instr[0] || out_pc !== mq_pc[0] ||
                out_instruction_type !== cls[3:1] || out_illegal !== cls[0])
               $display("FAIL rand_head cyc %0d got i=%h pc=%h t=%0d ill=%b exp i=%h pc=%h t=%0d ill=%b", c,
                        out_instruction, out_pc, out_instruction_type, out_illegal,
                        mq_instr[0], mq_pc[0], cls[3:1], cls[0]);
            else passed++;
         end
         r = $urandom();
         in_instruction = {r[31:7], ops[$urandom_range(0, 12)]};
         in_pc          = $urandom();
         in_valid       = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         flush          = ($urandom_range(0, 39) == 0);
         if (flush) begin
            mq_instr.delete(); mq_pc.delete();
         end else begin
            do_pop  = out_ready && (sz > 0);
            do_push = in_valid && (sz < DEPTH);
            if (do_pop) begin
               void'(mq_instr.pop_front()); void'(mq_pc.pop_front());
            end
            if (do_push) begin
               mq_instr.push_back(in_instruction); mq_pc.push_back(in_pc);
            end
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instruction = 32'h00A00113 + 32'(i << 20); in_pc = 32'h300 + 32'(i * 4);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      #3;
      reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0 || out_instruction !== 32'h0 || out_pc !== 32'h0)
         $display("FAIL async_reset got v=%b rdy=%b occ=%0d i=%h pc=%h exp 0 1 0 0 0", out_valid, in_ready,
                  occupancy, out_instruction, out_pc);
      else passed++;
      #10;
      reset = 1'b0;
      idle_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
